// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with exact occupancy count, programmable thresholds and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a registered read port.
module sync_fifo_ctrl #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AFULL_LVL  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AEMPTY_LVL = (ASIZE+1)'(AEMPTY_TH);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE-1:0] raddr;
  logic             wen;
  logic             ren;

  assign waddr = wptr[ASIZE-1:0];
  assign raddr = rptr[ASIZE-1:0];

  // The extra MSB on each pointer separates "same slot, full" from "same slot, empty".
  assign wfull        = (wptr[ASIZE] != rptr[ASIZE]) && (waddr == raddr);
  assign rempty       = (wptr == rptr);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AFULL_LVL);
  assign almost_empty = (count <= AEMPTY_LVL);

  assign wen = winc && !wfull;
  assign ren = rinc && !rempty;

  always_ff @(posedge clk) begin
    if (wen && !rst) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wen) begin
        wptr <= wptr + 1'b1;
      end
      if (ren) begin
        rptr <= rptr + 1'b1;
      end
      overflow  <= winc && wfull;
      underflow <= rinc && rempty;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is always presented; forced to zero while empty so the output never shows stale data.
  assign rdata = rempty ? '0 : mem[raddr];
`else
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (ren) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: an occupancy model plus a data scoreboard queue.
// Works for both the default build and a FIFO_FWFT_EN build.
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic [7:0] wdata;
  logic       winc;
  logic       rinc;
  logic [7:0] rdata;
  logic       wfull;
  logic       rempty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  logic [7:0] sb[$];
  logic [7:0] exp_data;
  logic [7:0] got;
  int         mcount;
  int         total;
  int         bad;
  bit         wr_acc;
  bit         rd_acc;

  sync_fifo_ctrl #(
    .DSIZE(8), .ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(2)
  ) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc),
    .rdata(rdata), .wfull(wfull), .rempty(rempty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock of stimulus; the model decides acceptance and captures the word a read should return.
  task automatic step(input bit w, input bit r, input logic [7:0] d);
    wr_acc = w && (mcount < DEPTH);
    rd_acc = r && (mcount > 0);
    winc   = w;
    rinc   = r;
    wdata  = d;
    if (wr_acc) sb.push_back(d);
`ifdef FIFO_FWFT_EN
    got = rdata;
`endif
    @(posedge clk);
    #1;
`ifndef FIFO_FWFT_EN
    got = rdata;
`endif
    winc   = 1'b0;
    rinc   = 1'b0;
    mcount = mcount + (wr_acc ? 1 : 0) - (rd_acc ? 1 : 0);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    winc  = 1'b1;
    rinc  = 1'b1;
    wdata = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", rdata); end
    total++; if (wfull !== 1'b0) begin bad++; $display("FAIL reset_wfull got=%0b exp=0", wfull); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL reset_rempty got=%0b exp=1", rempty); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull got=%0b exp=0", almost_full); end
    total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_aempty got=%0b exp=1", almost_empty); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL reset_err_pulse got=%0b%0b exp=00", overflow, underflow);
    end
    rst = 1'b0;
    sb.delete();
    mcount = 0;
    step(1'b0, 1'b0, 8'h00);
    total++; if (overflow !== 1'b0 || underflow !== 1'b0 || count !== 5'd0) begin
      bad++; $display("FAIL reset_release got=%0b%0b/%0d exp=00/0", overflow, underflow, count);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 8'(i));
      total++; if (count !== 5'(i + 1)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
      total++; if (almost_full !== (i + 1 >= 14)) begin bad++; $display("FAIL fill_afull got=%0b exp=%0b", almost_full, i + 1 >= 14); end
      total++; if (wfull !== (i + 1 == DEPTH)) begin bad++; $display("FAIL fill_wfull got=%0b exp=%0b", wfull, i + 1 == DEPTH); end
      total++; if (rempty !== 1'b0) begin bad++; $display("FAIL fill_rempty got=%0b exp=0", rempty); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00);
      exp_data = sb.pop_front();
      total++; if (got !== exp_data) begin bad++; $display("FAIL drain_data got=%0h exp=%0h", got, exp_data); end
      total++; if (count !== 5'(15 - i)) begin bad++; $display("FAIL drain_count got=%0d exp=%0d", count, 15 - i); end
      total++; if (almost_empty !== (15 - i <= 2)) begin bad++; $display("FAIL drain_aempty got=%0b exp=%0b", almost_empty, 15 - i <= 2); end
      total++; if (rempty !== (i == 15)) begin bad++; $display("FAIL drain_rempty got=%0b exp=%0b", rempty, i == 15); end
    end
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    step(1'b1, 1'b0, 8'hAA);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%0b exp=1", overflow); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
    step(1'b0, 1'b0, 8'h00);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
    while (mcount > 0) begin
      step(1'b0, 1'b1, 8'h00);
      exp_data = sb.pop_front();
      total++; if (got !== exp_data) begin bad++; $display("FAIL ovf_drain_data got=%0h exp=%0h", got, exp_data); end
    end
    step(1'b0, 1'b1, 8'h00);
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_pulse got=%0b exp=1", underflow); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL unf_count got=%0d exp=0", count); end
    step(1'b0, 1'b0, 8'h00);
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_clear got=%0b exp=0", underflow); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 8'(8'h40 + i));
      exp_data = sb.pop_front();
      total++; if (got !== exp_data) begin bad++; $display("FAIL b2b_data got=%0h exp=%0h", got, exp_data); end
      total++; if (count !== 5'd5) begin bad++; $display("FAIL b2b_count got=%0d exp=5", count); end
    end
    while (mcount < DEPTH) step(1'b1, 1'b0, 8'(8'h80 + mcount));
    step(1'b1, 1'b1, 8'hE7);
    exp_data = sb.pop_front();
    total++; if (got !== exp_data) begin bad++; $display("FAIL full_both_data got=%0h exp=%0h", got, exp_data); end
    total++; if (count !== 5'd15) begin bad++; $display("FAIL full_both_count got=%0d exp=15", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_both_ovf got=%0b exp=1", overflow); end
    while (mcount > 0) begin
      step(1'b0, 1'b1, 8'h00);
      exp_data = sb.pop_front();
      total++; if (got !== exp_data) begin bad++; $display("FAIL b2b_drain_data got=%0h exp=%0h", got, exp_data); end
    end
    step(1'b1, 1'b1, 8'h99);
    total++; if (count !== 5'd1) begin bad++; $display("FAIL empty_both_count got=%0d exp=1", count); end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL empty_both_unf got=%0b exp=1", underflow); end
    step(1'b0, 1'b1, 8'h00);
    exp_data = sb.pop_front();
    total++; if (got !== exp_data) begin bad++; $display("FAIL empty_both_data got=%0h exp=%0h", got, exp_data); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    total++; if (count !== 5'd9) begin bad++; $display("FAIL mid_pre_count got=%0d exp=9", count); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    mcount = 0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL mid_rempty got=%0b exp=1", rempty); end
    step(1'b1, 1'b0, 8'h5C);
    total++; if (rempty !== 1'b0) begin bad++; $display("FAIL mid_wr_rempty got=%0b exp=0", rempty); end
    step(1'b0, 1'b1, 8'h00);
    exp_data = sb.pop_front();
    total++; if (got !== 8'h5C || got !== exp_data) begin bad++; $display("FAIL mid_data got=%0h exp=5c", got); end
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    step(1'b1, 1'b0, 8'h3E);
    total++; if (rdata !== 8'h3E) begin bad++; $display("FAIL fwft_show got=%0h exp=3e", rdata); end
    step(1'b1, 1'b0, 8'h4F);
    total++; if (rdata !== 8'h3E) begin bad++; $display("FAIL fwft_hold got=%0h exp=3e", rdata); end
    step(1'b0, 1'b1, 8'h00);
    exp_data = sb.pop_front();
    total++; if (got !== exp_data) begin bad++; $display("FAIL fwft_pop got=%0h exp=%0h", got, exp_data); end
    total++; if (rdata !== 8'h4F) begin bad++; $display("FAIL fwft_next got=%0h exp=4f", rdata); end
    step(1'b0, 1'b1, 8'h00);
    exp_data = sb.pop_front();
    total++; if (got !== exp_data) begin bad++; $display("FAIL fwft_pop2 got=%0h exp=%0h", got, exp_data); end
  endtask
`endif

  initial begin
    total  = 0;
    bad    = 0;
    mcount = 0;
    rst    = 1'b1;
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = 8'h00;
    got    = 8'h00;
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_back_to_back();
    test_reset_mid();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
